// File: rtl/nested_loop_accum.sv
// Nested-loop accumulator: outer counter i, inner counter j, k += mode-selected delta
// per inner step; stops when i reaches I_MAX or k reaches K_BOUND, saturating on carry-out.
module nested_loop_accum #(
    parameter int W       = 16,
    parameter int I_MAX   = 60,
    parameter int K_BOUND = 2000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [W-1:0] i_init,
    input  logic [W-1:0] k_init,
    output logic [2:0]   state,
    output logic [W-1:0] k,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    // state   | meaning
    // CHECK   | clear j, test outer limit
    // INNER   | accumulate while j < i
    // ADVANCE | step outer counter
    // FINISH  | one-cycle done pulse
    // IDLE    | wait for start
    typedef enum logic [2:0] {
        CHECK   = 3'd0,
        INNER   = 3'd1,
        ADVANCE = 3'd2,
        FINISH  = 3'd3,
        IDLE    = 3'd4
    } state_t;

    localparam logic [W-1:0] I_MAX_W   = W'(I_MAX);
    localparam logic [W-1:0] K_BOUND_W = W'(K_BOUND);
    localparam logic [W-1:0] K_SAT     = '1;

    state_t       state_q;
    logic [W-1:0] k_q, i_q, j_q;
    logic [1:0]   mode_q;
    logic         busy_q, done_q, ovf_q;

    logic [W-1:0] delta_d;
    logic [W:0]   sum_d;
    logic         guard_d;

    always_comb begin
        delta_d = '0;
        case (mode_q)
            2'd0:    delta_d = i_q - j_q;
            2'd1:    delta_d = j_q;
            2'd2:    delta_d = i_q;
            default: delta_d = {{(W-1){1'b0}}, 1'b1};
        endcase
        sum_d   = {1'b0, k_q} + {1'b0, delta_d};
        guard_d = (k_q >= K_BOUND_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= {{(W-1){1'b0}}, 1'b1};
            i_q     <= {{(W-1){1'b0}}, 1'b1};
            j_q     <= '0;
            mode_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q     <= i_init;
                        k_q     <= k_init;
                        j_q     <= '0;
                        mode_q  <= mode;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // The bound guard takes priority and freezes k, i, j.
                    if (guard_d) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        j_q <= '0;
                        if (i_q < I_MAX_W) begin
                            state_q <= INNER;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    end
                end
                INNER: begin
                    if (guard_d) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else if (j_q < i_q) begin
                        if (sum_d[W]) begin
                            k_q   <= K_SAT;
                            ovf_q <= 1'b1;
                        end else begin
                            k_q <= sum_d[W-1:0];
                        end
                        j_q <= j_q + 1'b1;
                    end else begin
                        state_q <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (guard_d) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        i_q     <= i_q + 1'b1;
                        state_q <= CHECK;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign k        = k_q;
    assign i        = i_q;
    assign j        = j_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nested_loop_accum.sv
// Scoreboard bench: expected results are queued at start, monitors pop them on each done pulse.
module tb_nested_loop_accum;

    typedef struct {
        logic [15:0] k;
        logic [15:0] i;
        logic [15:0] j;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start16 = 1'b0;
    logic [1:0]  mode16 = 2'd0;
    logic [15:0] ii16 = '0, ki16 = '0;
    logic [2:0]  st16;
    logic [15:0] k16, i16, j16;
    logic        busy16, done16, ovf16;

    logic        start8 = 1'b0;
    logic [1:0]  mode8 = 2'd0;
    logic [7:0]  ii8 = '0, ki8 = '0;
    logic [2:0]  st8;
    logic [7:0]  k8, i8, j8;
    logic        busy8, done8, ovf8;

    nested_loop_accum dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16),
        .i_init(ii16), .k_init(ki16), .state(st16), .k(k16), .i(i16), .j(j16),
        .busy(busy16), .done(done16), .overflow(ovf16)
    );

    nested_loop_accum #(.W(8), .I_MAX(60), .K_BOUND(250)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
        .i_init(ii8), .k_init(ki8), .state(st8), .k(k8), .i(i8), .j(j8),
        .busy(busy8), .done(done8), .overflow(ovf8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q16[$];
    exp_t q8[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a done pulse is presented.
    always @(negedge clk) begin
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                check("dut16 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("dut16 k", k16, e.k);
                check("dut16 i", i16, e.i);
                check("dut16 j", j16, e.j);
                check("dut16 overflow", ovf16, e.ovf);
                check("dut16 state at done", st16, 32'd3);
                check("dut16 busy at done", busy16, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                check("dut8 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("dut8 k", k8, e.k);
                check("dut8 i", i8, e.i);
                check("dut8 j", j8, e.j);
                check("dut8 overflow", ovf8, e.ovf);
            end
        end
    end

    task automatic push16(input logic [15:0] k, input logic [15:0] i, input logic [15:0] j, input logic o);
        exp_t e;
        e.k = k; e.i = i; e.j = j; e.ovf = o;
        q16.push_back(e);
    endtask

    task automatic push8(input logic [15:0] k, input logic [15:0] i, input logic [15:0] j, input logic o);
        exp_t e;
        e.k = k; e.i = i; e.j = j; e.ovf = o;
        q8.push_back(e);
    endtask

    task automatic start_16(input logic [1:0] m, input logic [15:0] ii, input logic [15:0] kk);
        @(negedge clk);
        start16 = 1'b1; mode16 = m; ii16 = ii; ki16 = kk;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic start_8(input logic [1:0] m, input logic [7:0] ii, input logic [7:0] kk);
        @(negedge clk);
        start8 = 1'b1; mode8 = m; ii8 = ii; ki8 = kk;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_idle16(input string name);
        for (int c = 0; c < 5000; c++) begin
            if (!busy16) break;
            @(negedge clk);
        end
        check(name, busy16, 32'd0);
    endtask

    task automatic wait_idle8(input string name);
        for (int c = 0; c < 200; c++) begin
            if (!busy8) break;
            @(negedge clk);
        end
        check(name, busy8, 32'd0);
    endtask

    initial begin
        #12;
        check("reset state", st16, 32'd4);
        check("reset k", k16, 32'd1);
        check("reset i", i16, 32'd1);
        check("reset j", j16, 32'd0);
        check("reset busy", busy16, 32'd0);
        check("reset done", done16, 32'd0);
        check("reset overflow", ovf16, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0 from (1,1): guard trips inside outer iteration 22
        push16(16'd2004, 16'd22, 16'd16, 1'b0);
        start_16(2'd0, 16'd1, 16'd1);
        check("busy after start", busy16, 32'd1);
        wait_idle16("run mode0 timeout");

        // mode 3 from (1,0): sum 1..59, finishes from CHECK with i=60
        push16(16'd1770, 16'd60, 16'd0, 1'b0);
        start_16(2'd3, 16'd1, 16'd0);
        wait_idle16("run mode3 timeout");

        // mode 1 from (1,0): C(23,3)=1771 after i=22, then 0+1+..+21 -> 2002
        push16(16'd2002, 16'd23, 16'd22, 1'b0);
        start_16(2'd1, 16'd1, 16'd0);
        wait_idle16("run mode1 timeout");

        // mode 2 from (10,0): squares 10..18 = 1824, then 10 steps of 19 -> 2014
        push16(16'd2014, 16'd19, 16'd10, 1'b0);
        start_16(2'd2, 16'd10, 16'd0);
        wait_idle16("run mode2 timeout");

        // immediate termination on i_init >= I_MAX, with state sequence
        push16(16'd5, 16'd60, 16'd0, 1'b0);
        start_16(2'd0, 16'd60, 16'd5);
        check("imm cycle1 state", st16, 32'd0);
        @(negedge clk);
        check("imm cycle2 state", st16, 32'd3);
        check("imm cycle2 done", done16, 32'd1);
        @(negedge clk);
        check("imm cycle3 state", st16, 32'd4);
        check("imm cycle3 busy", busy16, 32'd0);
        check("imm cycle3 done", done16, 32'd0);

        // immediate termination on k_init >= K_BOUND, accepted in first IDLE cycle
        push16(16'd2000, 16'd5, 16'd0, 1'b0);
        start16 = 1'b1; mode16 = 2'd0; ii16 = 16'd5; ki16 = 16'd2000;
        @(negedge clk);
        start16 = 1'b0;
        check("kbound start accepted", st16, 32'd0);
        wait_idle16("run kbound timeout");

        // start re-pulsed while busy is ignored
        push16(16'd2004, 16'd22, 16'd16, 1'b0);
        start_16(2'd0, 16'd1, 16'd1);
        repeat (50) @(negedge clk);
        check("busy before re-pulse", busy16, 32'd1);
        start_16(2'd3, 16'd5, 16'd7);
        wait_idle16("run repulse timeout");

        // asynchronous reset mid-run while in INNER
        start_16(2'd0, 16'd1, 16'd1);
        for (int c = 0; c < 100; c++) begin
            if (st16 == 3'd1 && j16 != 16'd0) break;
            @(negedge clk);
        end
        check("reached INNER", st16, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst state", st16, 32'd4);
        check("async rst k", k16, 32'd1);
        check("async rst i", i16, 32'd1);
        check("async rst j", j16, 32'd0);
        check("async rst busy", busy16, 32'd0);
        check("async rst done", done16, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push16(16'd117, 16'd60, 16'd0, 1'b0);
        start_16(2'd3, 16'd58, 16'd0);
        wait_idle16("run after reset timeout");

        // narrow instance: first INNER step saturates
        push8(16'd255, 16'd20, 16'd1, 1'b1);
        start_8(2'd2, 8'd20, 8'd240);
        wait_idle8("run sat timeout");
        check("overflow sticky in IDLE", ovf8, 32'd1);
        push8(16'd5, 16'd60, 16'd0, 1'b0);
        start_8(2'd0, 8'd60, 8'd5);
        check("overflow cleared by start", ovf8, 32'd0);
        wait_idle8("run clear timeout");

        repeat (3) @(negedge clk);
        check("dut16 queue drained", q16.size(), 32'd0);
        check("dut8 queue drained", q8.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
